// File: rtl/seq_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
// Provides the control FSM state encoding and the counter-width helper.
package seq_mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        FIX  = ST_FIX
    } state_e;

    // Bits needed to count WIDTH-1 down to 0.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Request/response bundle for the sequential multiplier.
//   start, signed_mode, multiplicand, multiplier : requester -> multiplier
//   busy, done, product                          : multiplier -> requester
interface seq_shift_add_multiplier_if #(
    parameter int unsigned WIDTH = 32
);

    logic                   start;
    logic                   signed_mode;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output busy, done, product
    );

endinterface

// File: rtl/seq_mult_ctrl.sv
// Control unit for the shift-and-add multiplier: FSM, iteration counter,
// registered busy/done, and per-cycle datapath enables.
//   clk, reset      : clock, async active-high reset
//   start, zero_op  : request and "an operand is zero" qualifier
//   busy, done      : registered status outputs
//   load_c, step_c, fix_c, zero_c : combinational datapath enables
module seq_mult_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          EARLY_ZERO = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic zero_op,
    output logic busy,
    output logic done,
    output logic load_c,
    output logic step_c,
    output logic fix_c,
    output logic zero_c
);
    import seq_mult_pkg::*;

    localparam int unsigned   CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // State and status registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state, counter and enable decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load_c  = 1'b0;
        step_c  = 1'b0;
        fix_c   = 1'b0;
        zero_c  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (EARLY_ZERO && zero_op) begin
                        // Result is trivially zero: complete without going busy.
                        zero_c = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        load_c  = 1'b1;
                        cnt_d   = CNT_LOAD;
                        busy_d  = 1'b1;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                step_c = 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            FIX: begin
                fix_c   = 1'b1;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Parametrised sequential shift-and-add multiplier, signed or unsigned.
// Operands are converted to magnitudes, multiplied over WIDTH add+shift
// cycles, and the sign is re-applied in a final fix-up cycle.
//   clk, reset : clock, async active-high reset
//   bus        : start/signed_mode/multiplicand/multiplier in,
//                busy/done/product out (all outputs registered)
module seq_shift_add_multiplier #(
    parameter int unsigned WIDTH      = 32,
    parameter bit          EARLY_ZERO = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset,
    seq_shift_add_multiplier_if.slave   bus
);
    import seq_mult_pkg::*;

    localparam int unsigned PW = 2 * WIDTH;

    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH:0]   acc_q, acc_d;
    logic             sign_q, sign_d;
    logic [PW-1:0]    product_q, product_d;

    logic [WIDTH:0]   sum_c;
    logic [PW-1:0]    raw_c;
    logic             zero_op_c;
    logic             load_c, step_c, fix_c, zero_c;
    logic             busy, done;

    // Magnitude of a value; the most negative value maps to 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    assign zero_op_c = (bus.multiplicand == '0) || (bus.multiplier == '0);

    seq_mult_ctrl #(
        .WIDTH      (WIDTH),
        .EARLY_ZERO (EARLY_ZERO)
    ) u_ctrl (
        .clk     (clk),
        .reset   (reset),
        .start   (bus.start),
        .zero_op (zero_op_c),
        .busy    (busy),
        .done    (done),
        .load_c  (load_c),
        .step_c  (step_c),
        .fix_c   (fix_c),
        .zero_c  (zero_c)
    );

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q       <= '0;
            q_q       <= '0;
            acc_q     <= '0;
            sign_q    <= 1'b0;
            product_q <= '0;
        end else begin
            m_q       <= m_d;
            q_q       <= q_d;
            acc_q     <= acc_d;
            sign_q    <= sign_d;
            product_q <= product_d;
        end
    end

    // One extra bit keeps the carry of max*max.
    assign sum_c = acc_q + (q_q[0] ? {1'b0, m_q} : '0);
    assign raw_c = {acc_q[WIDTH-1:0], q_q};

    // Datapath next-state: load, add+shift, sign fix-up, zero shortcut.
    always_comb begin
        m_d       = m_q;
        q_d       = q_q;
        acc_d     = acc_q;
        sign_d    = sign_q;
        product_d = product_q;
        if (load_c) begin
            m_d    = mag(bus.multiplicand, bus.signed_mode);
            q_d    = mag(bus.multiplier, bus.signed_mode);
            acc_d  = '0;
            sign_d = bus.signed_mode & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
        end
        if (step_c) begin
            acc_d = {1'b0, sum_c[WIDTH:1]};
            q_d   = {sum_c[0], q_q[WIDTH-1:1]};
        end
        if (fix_c) begin
            product_d = sign_q ? (~raw_c + PW'(1)) : raw_c;
        end
        if (zero_c) begin
            product_d = '0;
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product_q;

endmodule
